// File: rtl/multicycle_ctrl_fsm.sv
// Control FSM for the shared-memory multi-cycle MIPS datapath: decodes the IR
// opcode into per-state strobes, handshakes with memory, counts retirements, traps on faults.

`ifndef ALUCONTROL_SIZE
`define ALUCONTROL_SIZE 3
`endif
`ifndef ALU_NONE
`define ALU_NONE 3'd0
`endif
`ifndef ALU_ADD
`define ALU_ADD 3'd1
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'd2
`endif
`ifndef ALU_OR
`define ALU_OR 3'd3
`endif
`ifndef FUNC_ADD
`define FUNC_ADD 6'h20
`endif

module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [5:0]                  opcode_in,
    input  logic [5:0]                  funccode_in,
    input  logic                        alu_zero,
    input  logic                        mem_ready,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic                        IorD,
    output logic                        IRWrite,
    output logic                        PCWrite,
    output logic [1:0]                  PCSource,
    output logic                        ALUSrcA,
    output logic [1:0]                  ALUSrcB,
    output logic [`ALUCONTROL_SIZE-1:0] ALUControl,
    output logic [1:0]                  SigExtendSignal,
    output logic                        RegWrite,
    output logic                        RegDst,
    output logic                        MemtoReg,
    output logic                        retire,
    output logic [CNT_W-1:0]            retire_cnt,
    output logic [3:0]                  state_out,
    output logic [1:0]                  err_code
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_TRAP   = 4'd15
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [TMO_W-1:0]   tmo_r;
    logic [TMO_W-1:0]   tmo_s;
    logic [1:0]         err_r;
    logic [1:0]         err_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               tmo_hit_s;

    assign state_out  = state_r;
    assign err_code   = err_r;
    assign retire_cnt = cnt_r;
    // An unanswered request in its last allowed cycle expires the access.
    assign tmo_hit_s  = (tmo_r == TMO_LAST);

    // Next-state and per-state datapath strobes.
    always_comb begin
        state_s         = state_r;
        err_s           = err_r;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        IorD            = 1'b0;
        IRWrite         = 1'b0;
        PCWrite         = 1'b0;
        PCSource        = 2'b00;
        ALUSrcA         = 1'b0;
        ALUSrcB         = 2'b00;
        ALUControl      = `ALU_NONE;
        SigExtendSignal = 2'b00;
        RegWrite        = 1'b0;
        RegDst          = 1'b0;
        MemtoReg        = 1'b0;
        retire          = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = `ALU_ADD;
                IRWrite    = mem_ready;
                PCWrite    = mem_ready;
                if (mem_ready) begin
                    state_s = S_DECODE;
                end else if (tmo_hit_s) begin
                    state_s = S_TRAP;
                    err_s   = 2'b10;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcB         = 2'b11;
                SigExtendSignal = 2'b01;
                ALUControl      = `ALU_ADD;
                case (opcode_in)
                    OP_LW, OP_SW:              state_s = S_MEMADR;
                    OP_ADDIU, OP_ORI, OP_LUI:  state_s = S_EXEC;
                    OP_BEQ:                    state_s = S_BRANCH;
                    OP_J:                      state_s = S_JUMP;
                    OP_RTYPE: begin
                        if (funccode_in == `FUNC_ADD) begin
                            state_s = S_EXEC;
                        end else begin
                            state_s = S_TRAP;
                            err_s   = 2'b01;
                        end
                    end
                    default: begin
                        state_s = S_TRAP;
                        err_s   = 2'b01;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA         = 1'b1;
                ALUSrcB         = 2'b10;
                SigExtendSignal = 2'b01;
                ALUControl      = `ALU_ADD;
                if (opcode_in == OP_SW) begin
                    state_s = S_MEMWR;
                end else begin
                    state_s = S_MEMRD;
                end
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_s = S_MEMWB;
                end else if (tmo_hit_s) begin
                    state_s = S_TRAP;
                    err_s   = 2'b10;
                end else begin
                    state_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_s  = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                IorD    = 1'b1;
                retire  = mem_ready;
                if (mem_ready) begin
                    state_s = S_FETCH;
                end else if (tmo_hit_s) begin
                    state_s = S_TRAP;
                    err_s   = 2'b10;
                end else begin
                    state_s = S_MEMWR;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                state_s = S_ALUWB;
                case (opcode_in)
                    OP_RTYPE: begin
                        ALUSrcB    = 2'b00;
                        ALUControl = `ALU_ADD;
                    end
                    OP_ADDIU: begin
                        ALUSrcB         = 2'b10;
                        SigExtendSignal = 2'b01;
                        ALUControl      = `ALU_ADD;
                    end
                    OP_ORI: begin
                        ALUSrcB         = 2'b10;
                        SigExtendSignal = 2'b00;
                        ALUControl      = `ALU_OR;
                    end
                    // rs is $0 in a LUI encoding, so ADD passes imm<<16 through.
                    OP_LUI: begin
                        ALUSrcB         = 2'b10;
                        SigExtendSignal = 2'b10;
                        ALUControl      = `ALU_ADD;
                    end
                    default: ALUControl = `ALU_NONE;
                endcase
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = (opcode_in == OP_RTYPE);
                retire   = 1'b1;
                state_s  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b00;
                ALUControl = `ALU_SUB;
                PCSource   = 2'b01;
                PCWrite    = alu_zero;
                retire     = 1'b1;
                state_s    = S_FETCH;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                retire   = 1'b1;
                state_s  = S_FETCH;
            end
            S_TRAP:  state_s = S_TRAP;
            default: state_s = S_TRAP;
        endcase
    end

    // Timeout counter: restarts on every state change, counts unanswered request cycles.
    always_comb begin
        tmo_s = tmo_r;
        if (state_s != state_r) begin
            tmo_s = '0;
        end else if (mem_req && !mem_ready) begin
            tmo_s = tmo_r + TMO_ONE;
        end else begin
            tmo_s = tmo_r;
        end
    end

    // State, timeout, sticky error and retire counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
            tmo_r   <= '0;
            err_r   <= 2'b00;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            tmo_r   <= tmo_s;
            err_r   <= err_s;
            if (retire) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: directed scenarios plus a random
// instruction stream, each checked cycle by cycle against per-instruction step profiles.

module tb_multicycle_ctrl_fsm;

    localparam int TMO = 4;
    localparam int CW  = 8;

    localparam logic [2:0] A_NONE = 3'd0;
    localparam logic [2:0] A_ADD  = 3'd1;
    localparam logic [2:0] A_SUB  = 3'd2;
    localparam logic [2:0] A_OR   = 3'd3;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    opcode_in;
    logic [5:0]    funccode_in;
    logic          alu_zero;
    logic          mem_ready;
    logic          mem_req, mem_we, IorD, IRWrite, PCWrite;
    logic [1:0]    PCSource;
    logic          ALUSrcA;
    logic [1:0]    ALUSrcB;
    logic [2:0]    ALUControl;
    logic [1:0]    SigExtendSignal;
    logic          RegWrite, RegDst, MemtoReg, retire;
    logic [CW-1:0] retire_cnt;
    logic [3:0]    state_out;
    logic [1:0]    err_code;
    logic [18:0]   ctl_vec;

    int            vectors = 0;
    int            miscompares = 0;
    logic [CW-1:0] exp_cnt;
    logic [1:0]    exp_err;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode_in(opcode_in), .funccode_in(funccode_in),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .SigExtendSignal(SigExtendSignal), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .retire(retire), .retire_cnt(retire_cnt),
        .state_out(state_out), .err_code(err_code)
    );

    always #5 clk = ~clk;

    assign ctl_vec = {mem_req, mem_we, IorD, IRWrite, PCWrite, PCSource, ALUSrcA, ALUSrcB,
                      ALUControl, SigExtendSignal, RegWrite, RegDst, MemtoReg, retire};

    function automatic logic [18:0] ctl(input logic mreq, input logic we, input logic iord,
                                        input logic irw, input logic pcw, input logic [1:0] pcs,
                                        input logic sa, input logic [1:0] sb, input logic [2:0] alu,
                                        input logic [1:0] se, input logic rw, input logic rd,
                                        input logic m2r, input logic ret);
        return {mreq, we, iord, irw, pcw, pcs, sa, sb, alu, se, rw, rd, m2r, ret};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply inputs after the falling edge, check, then wait for the rising edge.
    task automatic cyc(input string tag, input logic rdy, input logic zero,
                       input logic [3:0] es, input logic [18:0] ectl);
        @(negedge clk);
        mem_ready = rdy;
        alu_zero  = zero;
        #1;
        chk({tag, "/state"}, 32'(state_out), 32'(es));
        chk({tag, "/ctl"}, 32'(ctl_vec), 32'(ectl));
        chk({tag, "/err"}, 32'(err_code), 32'(exp_err));
        chk({tag, "/cnt"}, 32'(retire_cnt), 32'(exp_cnt));
        @(posedge clk);
    endtask

    task automatic do_reset();
        #1;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        #1;
        exp_cnt = '0;
        exp_err = 2'b00;
        chk("rst/state", 32'(state_out), 32'd0);
        chk("rst/cnt", 32'(retire_cnt), 32'd0);
        chk("rst/err", 32'(err_code), 32'd0);
        chk("rst/mem_req", 32'(mem_req), 32'd1);
        chk("rst/mem_we", 32'(mem_we), 32'd0);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fetch_decode(input int fw);
        for (int i = 0; i < fw; i++)
            cyc("fetch_wait", 1'b0, rb(), 4'd0,
                ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd1, A_ADD, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc("fetch", 1'b1, rb(), 4'd0,
            ctl(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd1, A_ADD, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc("decode", rb(), rb(), 4'd1,
            ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd3, A_ADD, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                             input int mw, input logic z);
        logic [18:0] ec;
        #1;
        opcode_in   = op;
        funccode_in = fn;
        fetch_decode(fw);
        case (op)
            OP_LW, OP_SW: begin
                cyc("memadr", rb(), rb(), 4'd2,
                    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, A_ADD, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
                if (op == OP_LW) begin
                    for (int i = 0; i < mw; i++)
                        cyc("memrd_wait", 1'b0, rb(), 4'd3,
                            ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, A_NONE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
                    cyc("memrd", 1'b1, rb(), 4'd3,
                        ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, A_NONE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
                    cyc("memwb", rb(), rb(), 4'd4,
                        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, A_NONE, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1));
                end else begin
                    for (int i = 0; i < mw; i++)
                        cyc("memwr_wait", 1'b0, rb(), 4'd5,
                            ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, A_NONE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
                    cyc("memwr", 1'b1, rb(), 4'd5,
                        ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, A_NONE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
                end
            end
            OP_BEQ:
                cyc("branch", rb(), z, 4'd8,
                    ctl(1'b0, 1'b0, 1'b0, 1'b0, z, 2'd1, 1'b1, 2'd0, A_SUB, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
            OP_J:
                cyc("jump", rb(), rb(), 4'd9,
                    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, A_NONE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
            default: begin
                case (op)
                    OP_R:     ec = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, A_ADD, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                    OP_ADDIU: ec = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, A_ADD, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
                    OP_ORI:   ec = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, A_OR, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                    default:  ec = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, A_ADD, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
                endcase
                cyc("exec", rb(), rb(), 4'd6, ec);
                cyc("aluwb", rb(), rb(), 4'd7,
                    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, A_NONE, 2'd0, 1'b1, (op == OP_R), 1'b0, 1'b1));
            end
        endcase
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic run_illegal(input logic [5:0] op, input logic [5:0] fn);
        #1;
        opcode_in   = op;
        funccode_in = fn;
        fetch_decode(0);
        exp_err = 2'b01;
        for (int i = 0; i < 20; i++)
            cyc("trap_illegal", rb(), rb(), 4'd15, 19'd0);
    endtask

    initial begin
        logic [5:0] ops [8];
        int k;
        ops = '{OP_R, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J};
        rst_n       = 1'b0;
        mem_ready   = 1'b0;
        alu_zero    = 1'b0;
        opcode_in   = 6'h00;
        funccode_in = 6'h20;
        exp_cnt     = '0;
        exp_err     = 2'b00;
        @(posedge clk);
        do_reset();

        run_instr(OP_R, 6'h20, 0, 0, 1'b0);
        chk("add/retire_cnt_model", 32'(exp_cnt), 32'd1);
        run_instr(OP_LW, 6'h00, 0, 3, 1'b0);
        run_instr(OP_BEQ, 6'h00, 0, 0, 1'b1);
        run_instr(OP_BEQ, 6'h00, 0, 0, 1'b0);
        run_instr(OP_J, 6'h00, TMO - 1, 0, 1'b0);
        run_instr(OP_SW, 6'h00, 1, TMO - 1, 1'b0);

        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 7);
            run_instr(ops[k], (ops[k] == OP_R) ? 6'h20 : 6'($urandom_range(0, 63)),
                      $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), rb());
        end

        run_illegal(6'h3F, 6'h00);
        do_reset();
        run_illegal(OP_R, 6'h22);
        do_reset();

        #1;
        opcode_in = OP_R;
        funccode_in = 6'h20;
        for (int i = 0; i < TMO; i++)
            cyc("tmo_wait", 1'b0, rb(), 4'd0,
                ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd1, A_ADD, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_err = 2'b10;
        for (int i = 0; i < 5; i++)
            cyc("trap_tmo", rb(), rb(), 4'd15, 19'd0);
        do_reset();

        run_instr(OP_ORI, 6'h00, 0, 0, 1'b0);
        run_instr(OP_R, 6'h20, 0, 0, 1'b0);
        #1;
        opcode_in = OP_SW;
        fetch_decode(0);
        cyc("sw_memadr", 1'b0, rb(), 4'd2,
            ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, A_ADD, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc("sw_wait", 1'b0, rb(), 4'd5,
            ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, A_NONE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("midwr/mem_we_before", 32'(mem_we), 32'd1);
        chk("midwr/cnt_before", 32'(retire_cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        chk("midwr/state", 32'(state_out), 32'd0);
        chk("midwr/mem_we", 32'(mem_we), 32'd0);
        chk("midwr/cnt", 32'(retire_cnt), 32'd0);
        chk("midwr/err", 32'(err_code), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(OP_LUI, 6'h00, 0, 0, 1'b0);
        run_instr(OP_LW, 6'h00, 2, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
